// File: rtl/fpm_arb_pkg.sv
// Shared definitions for the fixed-point multiplier arbiter: pipeline depth,
// requester limit, the tag carried alongside each product, and the product
// width derivation used by both the arbiter top and the multiplier.
package fpm_arb_pkg;

  // Register stages inside fixed_point_mult; the tag pipe must match this.
  localparam int MULT_LATENCY = 2;

  // Largest NUM_REQ the 3-bit tag id can address.
  localparam int MAX_REQ = 8;

  // Travels alongside each product so the result can be routed to its issuer.
  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } fpm_tag_t;

  // Product width after dropping the surplus fractional bits of A*B.
  function automatic int fpm_p_width(input int a_width, input int a_frac,
                                     input int b_width, input int b_frac,
                                     input int p_frac);
    return a_width + b_width - (a_frac + b_frac - p_frac);
  endfunction

endpackage

// File: rtl/fixed_point_mult.sv
// Two-stage pipelined signed fixed-point multiplier. Stage 1 registers the
// operands, stage 2 registers the rescaled product. The rescale is an
// arithmetic right shift, so results truncate toward minus infinity.
module fixed_point_mult
  import fpm_arb_pkg::*;
#(
  parameter int  A_WIDTH     = 16,
  parameter int  A_FRAC_BITS = 14,
  parameter int  B_WIDTH     = 16,
  parameter int  B_FRAC_BITS = 14,
  parameter int  P_FRAC_BITS = 14,
  localparam int P_WIDTH     = fpm_p_width(A_WIDTH, A_FRAC_BITS, B_WIDTH,
                                           B_FRAC_BITS, P_FRAC_BITS)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [A_WIDTH-1:0] a_in,
  input  logic [B_WIDTH-1:0] b_in,
  output logic [P_WIDTH-1:0] p_out
);

  localparam int SHIFT  = A_FRAC_BITS + B_FRAC_BITS - P_FRAC_BITS;
  localparam int FULL_W = A_WIDTH + B_WIDTH;

  logic signed [A_WIDTH-1:0] r_a;
  logic signed [B_WIDTH-1:0] r_b;
  logic signed [FULL_W-1:0]  w_full;
  logic        [P_WIDTH-1:0] w_scaled;
  logic        [P_WIDTH-1:0] r_p;

  assign w_full   = r_a * r_b;
  assign w_scaled = P_WIDTH'(w_full >>> SHIFT);
  assign p_out    = r_p;

  // Operand stage followed by product stage; both clear on reset.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments let r_p pick up the product of the
    // operands captured on the previous edge, forming the second stage.
    if (rst_in) begin
      r_a <= '0;
      r_b <= '0;
      r_p <= '0;
    end else begin
      r_a <= a_in;
      r_b <= b_in;
      r_p <= w_scaled;
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr_in, wrapping modulo N, and reports it one-hot and as an index.
module rr_arbiter #(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_in,
  input  logic [IW-1:0] ptr_in,
  output logic [N-1:0]  grant_out,
  output logic [IW-1:0] grant_idx_out,
  output logic          grant_any_out
);

  // Scan from the pointer position and stop at the first requester found.
  always_comb begin
    int cand;
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    grant_out     = '0;
    grant_idx_out = '0;
    grant_any_out = 1'b0;
    cand          = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_in) + k) % N;
      if (!grant_any_out && req_in[cand]) begin
        grant_any_out   = 1'b1;
        grant_out[cand] = 1'b1;
        grant_idx_out   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/fixed_point_mult_arbiter.sv
// Shares one pipelined fixed_point_mult among NUM_REQ requesters with
// round-robin arbitration, one issue per cycle. A {valid,id} tag pipe
// running beside the multiplier routes each product back to its issuer.
// Optional performance counters are built when FPM_ARB_PERF_EN is defined.
module fixed_point_mult_arbiter
  import fpm_arb_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  A_WIDTH     = 16,
  parameter int  A_FRAC_BITS = 14,
  parameter int  B_WIDTH     = 16,
  parameter int  B_FRAC_BITS = 14,
  parameter int  P_FRAC_BITS = 14,
  localparam int P_WIDTH     = fpm_p_width(A_WIDTH, A_FRAC_BITS, B_WIDTH,
                                           B_FRAC_BITS, P_FRAC_BITS)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       hold_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a_in,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b_in,
  output logic [NUM_REQ-1:0]         resp_valid_out,
  output logic [P_WIDTH-1:0]         resp_p_out,
  output logic                       busy_out
`ifdef FPM_ARB_PERF_EN
  ,
  output logic [31:0]                issue_cnt_out,
  output logic [31:0]                stall_cnt_out
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_req_eligible;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_grant_any;
  logic [PTR_W-1:0]   r_ptr;
  logic [A_WIDTH-1:0] w_mul_a;
  logic [B_WIDTH-1:0] w_mul_b;
  logic [P_WIDTH-1:0] w_mul_p;
  fpm_tag_t           r_tag_s1;
  fpm_tag_t           r_tag_s2;

  // Nothing may be issued while held or while reset is asserted.
  assign w_req_eligible = (hold_in || rst_in) ? '0 : req_valid_in;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req_in        (w_req_eligible),
    .ptr_in        (r_ptr),
    .grant_out     (w_grant),
    .grant_idx_out (w_grant_idx),
    .grant_any_out (w_grant_any)
  );

  assign req_ready_out = w_grant;

  // Granted operands go straight onto the multiplier inputs.
  assign w_mul_a = req_a_in[int'(w_grant_idx)*A_WIDTH +: A_WIDTH];
  assign w_mul_b = req_b_in[int'(w_grant_idx)*B_WIDTH +: B_WIDTH];

  fixed_point_mult #(
    .A_WIDTH     (A_WIDTH),
    .A_FRAC_BITS (A_FRAC_BITS),
    .B_WIDTH     (B_WIDTH),
    .B_FRAC_BITS (B_FRAC_BITS),
    .P_FRAC_BITS (P_FRAC_BITS)
  ) u_fixed_point_mult (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .a_in   (w_mul_a),
    .b_in   (w_mul_b),
    .p_out  (w_mul_p)
  );

  // Round-robin pointer: the requester after the last winner gets top priority.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ptr <= '0;
    end else if (w_grant_any) begin
      r_ptr <= (int'(w_grant_idx) == NUM_REQ - 1) ? '0 : w_grant_idx + 1'b1;
    end
  end

  // Tag pipe mirrors the multiplier's two register stages.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_tag_s1 <= '0;
      r_tag_s2 <= '0;
    end else begin
      r_tag_s1.valid <= w_grant_any;
      r_tag_s1.id    <= 3'(w_grant_idx);
      r_tag_s2       <= r_tag_s1;
    end
  end

  // Decode the completing tag into a one-hot response strobe; a reset cycle
  // discards whatever is completing so no response escapes an aborted op.
  always_comb begin
    resp_valid_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid_out[i] = r_tag_s2.valid && !rst_in && (r_tag_s2.id == 3'(i));
    end
  end

  assign resp_p_out = w_mul_p;
  assign busy_out   = r_tag_s1.valid | r_tag_s2.valid;

`ifdef FPM_ARB_PERF_EN
  logic [31:0] r_issue_cnt;
  logic [31:0] r_stall_cnt;

  // Count handshakes and cycles in which some valid requester goes unserved.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_grant_any) begin
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if (|(req_valid_in & ~w_grant)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign issue_cnt_out = r_issue_cnt;
  assign stall_cnt_out = r_stall_cnt;
`endif

endmodule
